// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD add/subtract: one decimal digit slice stepped over SIZE digits,
// least-significant digit first, with start/busy/done handshake.

module bcd_digit_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       sub,
   input  logic       cin,
   output logic [3:0] dig,
   output logic       cout
);
   logic [3:0] b_eff;
   logic [4:0] s;

   always_comb begin
      // nine's complement of B; the +1 for ten's complement enters via the initial carry
      b_eff = sub ? (4'd9 - b) : b;
      s     = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
      if (s > 5'd9) begin
         dig  = 4'(s - 5'd10);
         cout = 1'b1;
      end else begin
         dig  = s[3:0];
         cout = 1'b0;
      end
   end
endmodule

module bcd_serial_adder_ctrl #(
   parameter int SIZE = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op,
   input  logic [SIZE*4-1:0] A,
   input  logic [SIZE*4-1:0] B,
   output logic              busy,
   output logic              done,
   output logic [SIZE*4-1:0] Answer,
   output logic              carry_out,
   output logic              error
);
   localparam int IDXW = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              op_q, op_d;
   logic [SIZE*4-1:0] a_q, a_d, b_q, b_d, ans_q, ans_d;
   logic              cout_q, cout_d, err_q, err_d;
   logic [3:0]        dig;
   logic              dig_cout;

   function automatic logic has_bad_digit(input logic [SIZE*4-1:0] v);
      has_bad_digit = 1'b0;
      for (int i = 0; i < SIZE; i++)
         if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
   endfunction

   bcd_digit_slice u_slice (
      .a    (a_q[{idx_q, 2'b00} +: 4]),
      .b    (b_q[{idx_q, 2'b00} +: 4]),
      .sub  (op_q),
      .cin  (carry_q),
      .dig  (dig),
      .cout (dig_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      ans_d   = ans_q;
      cout_d  = cout_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d    = A;
               b_d    = B;
               op_d   = op;
               ans_d  = '0;
               cout_d = 1'b0;
               err_d  = 1'b0;
               if (has_bad_digit(A) || has_bad_digit(B)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  idx_d   = '0;
                  carry_d = op;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            ans_d[{idx_q, 2'b00} +: 4] = dig;
            carry_d = dig_cout;
            if (idx_q == IDXW'(SIZE - 1)) begin
               cout_d  = dig_cout;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ans_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ans_q   <= ans_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign done      = (state_q == DONE);
   assign Answer    = ans_q;
   assign carry_out = cout_q;
   assign error     = err_q;
endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
- Digit-serial BCD add/subtract engine. One BCD digit adder slice is sequenced over SIZE digits, least-significant digit first, one digit per clock.
- Lab datapaths use it when area matters more than latency, in place of a fully unrolled SIZE-digit ripple BCD adder.
- Start/busy/done handshake. Result registers hold their value between operations.

Parameters:
- SIZE, 8, number of BCD digits per operand and result (1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
- A  input  SIZE*4  operand A, packed BCD, digit i at [4i+3:4i]; sampled with start.
- B  input  SIZE*4  operand B, same packing; sampled with start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse when result, carry_out and error become valid.
- Answer  output  SIZE*4  packed BCD result.
- carry_out  output  1  add: decimal carry out of MSD. Subtract: 1 = no borrow (A>=B).
- error  output  1  operand contained a non-BCD digit (>9).

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; busy=0, done=0, Answer=0, carry_out=0, error=0.
  - Digit index and internal carry are cleared.
  - Any in-flight operation is abandoned. No done pulse is produced for it.
- States are IDLE, RUN, DONE.
- IDLE:
  - On a clock edge with start=1, latch A, B and op into internal registers.
  - Clear Answer, carry_out and error.
  - Check every digit of the latched A and B. If any digit is >9, go to DONE with error=1, Answer=0, carry_out=0.
  - Otherwise set digit index=0 and carry=op (subtract injects +1), then go to RUN.
  - With start=0, stay in IDLE; outputs hold.
- RUN (exactly SIZE cycles):
  - Per cycle, digit i: a=A[i]; b = B[i] for add, 9-B[i] for subtract.
  - s = a+b+carry, a 5-bit value (0..19).
  - If s>9: the digit is s-10 and the new carry is 1. Otherwise the digit is s and the new carry is 0.
  - Write the digit into Answer[4i+:4] and update carry.
  - When i==SIZE-1: load carry_out with the final carry and go to DONE. Otherwise i=i+1.
- DONE (1 cycle): done=1, then return to IDLE. done is high only in this state.
- Latency:
  - The start edge is cycle 0. done is high in cycle SIZE+1 (normal path) or cycle 1 (error path).
  - The earliest next accepted start is at the edge ending the DONE cycle+1, i.e. the first cycle back in IDLE.
- Subtract result:
  - carry_out=1: Answer = A-B.
  - carry_out=0: Answer = ten's complement, i.e. 10^SIZE + A - B. No re-complementing is done.
- Add overflow: Answer = (A+B) mod 10^SIZE, with carry_out=1.
- Start while busy (RUN/DONE) is ignored. Changes to A, B and op while busy have no effect.
- Answer digits above the current index during RUN read 0. Answer is only guaranteed valid from done onward, and it holds until the next accepted start.
- Latched op is constant for the whole operation.

Test Plan (SIZE=4):
- Add: A=0x1234, B=0x5678, op=0, pulse start → done in cycle 5; Answer=0x6912, carry_out=0, error=0. busy is high in cycles 1-5.
- Overflow: A=0x9999, B=0x0001, op=0 → Answer=0x0000, carry_out=1; a per-digit carry ripple occurs every RUN cycle.
- Subtract: A=0x0500, B=0x0123, op=1 → Answer=0x0377, carry_out=1. Then swap operands (A=0x0123, B=0x0500) → Answer=0x9623, carry_out=0.
- Invalid digit: A=0x00A0, B=0x0001, op=0 → done in cycle 1 with error=1, Answer=0, carry_out=0, and no RUN cycles. A following valid start clears error.
- Start while busy: during RUN of 0x1111+0x2222, assert start with A=0x9999 → ignored; Answer=0x3333, and exactly one done pulse.
- Reset mid-operation: assert rst_n=0 in cycle 2 of a RUN → busy, done and Answer go to 0 immediately. No done pulse follows, and a new start after release completes normally.
